// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing description, 1600x1200@60 defaults and region helpers
package vga_pkg;
  typedef struct packed {
    int visible;
    int front;
    int sync;
    int back;
  } vga_timing_t;
  localparam vga_timing_t VGA_H_DEFAULT = '{visible: 1600, front: 64, sync: 192, back: 304};
  localparam vga_timing_t VGA_V_DEFAULT = '{visible: 1200, front: 1, sync: 3, back: 46};
  function automatic int total(input vga_timing_t t);
    return t.visible + t.front + t.sync + t.back;
  endfunction
  function automatic int sync_start(input vga_timing_t t);
    return t.visible + t.front;
  endfunction
  function automatic int sync_end(input vga_timing_t t);
    return t.visible + t.front + t.sync - 1;
  endfunction
  function automatic bit timing_ok(input vga_timing_t t);
    return t.visible >= 1 && t.front >= 1 && t.sync >= 1 && t.back >= 1;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: DEPTH-stage shift register with synchronous clear
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) sr <= '{default: '0};
      else begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA counters, sync and latency-aligned colour output
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VGA_H_DEFAULT.visible,
  parameter int H_FRONT   = VGA_H_DEFAULT.front,
  parameter int H_SYNC    = VGA_H_DEFAULT.sync,
  parameter int H_BACK    = VGA_H_DEFAULT.back,
  parameter int V_VISIBLE = VGA_V_DEFAULT.visible,
  parameter int V_FRONT   = VGA_V_DEFAULT.front,
  parameter int V_SYNC    = VGA_V_DEFAULT.sync,
  parameter int V_BACK    = VGA_V_DEFAULT.back,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int COLOR_W   = 4,
  parameter int LATENCY   = 1,
  localparam vga_timing_t H_T = '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK},
  localparam vga_timing_t V_T = '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK},
  localparam int XW = $clog2(total(H_T)),
  localparam int YW = $clog2(total(V_T))
) (
  input  logic                 clock_162,
  input  logic                 rst,
  output logic                 pixel_req,
  output logic [XW-1:0]        pixel_x,
  output logic [YW-1:0]        pixel_y,
  output logic                 line_start,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic [COLOR_W-1:0]   RED,
  output logic [COLOR_W-1:0]   GREEN,
  output logic [COLOR_W-1:0]   BLUE,
  output logic                 HSYNC,
  output logic                 VSYNC
);
  localparam logic HP = HSYNC_POL != 0;
  localparam logic VP = VSYNC_POL != 0;
  if (!timing_ok(H_T) || !timing_ok(V_T) || LATENCY < 0 || LATENCY > 8) begin : g_bad_params
    $error("vga_timing_gen: invalid timing parameters");
  end
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic last_col, last_row, visible, h_act, v_act, d_vis, d_h, d_v;
  assign last_col = col == XW'(total(H_T) - 1);
  assign last_row = row == YW'(total(V_T) - 1);
  always_ff @(posedge clock_162) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= last_col ? '0 : col + 1'b1;
      if (last_col) row <= last_row ? '0 : row + 1'b1;
    end
  end
  assign visible     = col < XW'(H_VISIBLE) && row < YW'(V_VISIBLE);
  assign h_act       = col >= XW'(sync_start(H_T)) && col <= XW'(sync_end(H_T));
  assign v_act       = row >= YW'(sync_start(V_T)) && row <= YW'(sync_end(V_T));
  assign pixel_req   = visible;
  assign pixel_x     = col;
  assign pixel_y     = row;
  assign line_start  = col == '0;
  assign frame_start = col == '0 && row == '0;
  vga_delay_line #(.WIDTH(3), .DEPTH(LATENCY)) u_align (
    .clk (clock_162),
    .rst (rst),
    .d   ({visible, h_act, v_act}),
    .q   ({d_vis, d_h, d_v})
  );
  always_ff @(posedge clock_162) begin
    if (rst) begin
      {RED, GREEN, BLUE} <= '0;
      HSYNC              <= ~HP;
      VSYNC              <= ~VP;
    end else begin
      {RED, GREEN, BLUE} <= d_vis ? rgb_in : '0;
      HSYNC              <= HP ? d_h : ~d_h;
      VSYNC              <= VP ? d_v : ~d_v;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-colour check of a small VGA config against a frame-arithmetic model
module tb_vga_timing_gen;
  localparam int HV = 8, HF = 1, HS = 2, HB = 1;
  localparam int VV = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int LAT = 3;
  localparam int HPOL = 0, VPOL = 1;
  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_req, line_start, frame_start, hsync, vsync;
  logic [3:0]  pixel_x;
  logic [2:0]  pixel_y;
  logic [11:0] rgb_in;
  logic [3:0]  red, green, blue;
  logic [11:0] hist [0:1023];
  int          n, n_chk, n_fail;
  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(4), .LATENCY(LAT)
  ) dut (
    .clock_162   (clk),
    .rst         (rst),
    .pixel_req   (pixel_req),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .rgb_in      (rgb_in),
    .RED         (red),
    .GREEN       (green),
    .BLUE        (blue),
    .HSYNC       (hsync),
    .VSYNC       (vsync)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask
  task automatic reset_for(input int k);
    rst = 1'b1;
    repeat (k) begin
      @(posedge clk);
      #1;
      chk("rst_x", 32'(pixel_x), 0);
      chk("rst_y", 32'(pixel_y), 0);
      chk("rst_rgb", 32'({red, green, blue}), 0);
      chk("rst_hsync", 32'(hsync), HPOL == 0 ? 1 : 0);
      chk("rst_vsync", 32'(vsync), VPOL == 0 ? 1 : 0);
    end
    rst = 1'b0;
    n = 0;
  endtask
  task automatic run(input int cycles);
    int c, r, t, tc, tr;
    bit vis, hact, vact;
    logic [11:0] exp_rgb, v;
    for (int k = 0; k < cycles; k++) begin
      c = n % HT;
      r = (n / HT) % VT;
      chk("pixel_x", 32'(pixel_x), c);
      chk("pixel_y", 32'(pixel_y), r);
      chk("pixel_req", 32'(pixel_req), (c < HV && r < VV) ? 1 : 0);
      chk("line_start", 32'(line_start), c == 0 ? 1 : 0);
      chk("frame_start", 32'(frame_start), (c == 0 && r == 0) ? 1 : 0);
      t = n - LAT - 1;
      vis = 0; hact = 0; vact = 0;
      if (t >= 0) begin
        tc = t % HT;
        tr = (t / HT) % VT;
        vis  = tc < HV && tr < VV;
        hact = tc >= HV + HF && tc < HV + HF + HS;
        vact = tr >= VV + VF && tr < VV + VF + VS;
      end
      exp_rgb = vis ? hist[n-1] : 12'h000;
      chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
      chk("hsync", 32'(hsync), (HPOL != 0) == hact ? 1 : 0);
      chk("vsync", 32'(vsync), (VPOL != 0) == vact ? 1 : 0);
      v = ($urandom_range(3) == 0) ? 12'hFFF : 12'($urandom);
      hist[n] = v;
      rgb_in = v;
      n++;
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    n = 0;
    rgb_in = 12'hFFF;
    reset_for(5);
    run(3 * HT * VT + 10);
    reset_for(1);
    run(2 * HT + 5);
    reset_for(2);
    run(2 * HT * VT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
